rca_slice_sequencer: RTL and testbench



---
 rtl/rca_slice_sequencer_if.sv | 57 +++++
 rtl/rca_slice_sequencer.sv | 114 +++++++++++
 tb/tb_rca_slice_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rca_slice_sequencer_if.sv
// ---------------------------------------------------------------------------
// rca_slice_sequencer_if
//   Handshake/data bundle for the sequential wide adder.
//   Parameter W : operand/result width in bits.
//   Operand side : in_valid (m->s), in_ready (s->m), a, b (m->s)
//                  op (m->s, only when RCA_SEQ_SUB_EN is defined; 0=add 1=sub)
//   Result side  : res_valid (s->m), res_ready (m->s), sum, cout (s->m)
//   Status       : busy (s->m), high while an operation is in flight
//   Modports: master = producer/consumer side, slave = the sequencer.
//   Optional feature macro: RCA_SEQ_SUB_EN
// ---------------------------------------------------------------------------
interface rca_slice_sequencer_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef RCA_SEQ_SUB_EN
  logic         op;
`endif
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid,
    output a,
    output b,
`ifdef RCA_SEQ_SUB_EN
    output op,
`endif
    output res_ready,
    input  in_ready,
    input  res_valid,
    input  sum,
    input  cout,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
`ifdef RCA_SEQ_SUB_EN
    input  op,
`endif
    input  res_ready,
    output in_ready,
    output res_valid,
    output sum,
    output cout,
    output busy
  );
endinterface

// File: rtl/rca_slice_sequencer.sv
// ---------------------------------------------------------------------------
// rca_slice_sequencer
//   Computes a SLICE*CHUNKS-bit sum with a single SLICE-bit ripple-carry
//   slice, one chunk per clock, LSB chunk first. A registered carry links
//   the chunks. Result is held until the consumer accepts it.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : rca_slice_sequencer_if.slave (in_valid/in_ready/a/b[/op],
//             res_valid/res_ready/sum/cout, busy)
//   Optional feature macro: RCA_SEQ_SUB_EN
//     defined   -> bus.op selects add (0) or subtract (1), a - b = a + ~b + 1
//     undefined -> always adds, no op signal
// ---------------------------------------------------------------------------
module rca_slice_sequencer #(
  parameter int SLICE  = 4,
  parameter int CHUNKS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rca_slice_sequencer_if.slave  bus
);
  localparam int W  = SLICE * CHUNKS;
  localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            carry_q, cout_q, res_valid_q, busy_q;
  logic [CW-1:0]   cnt_q;

  // Bit-level ripple chain of the slice, carry-in from the carry register.
  logic [SLICE:0]   rc;
  logic [SLICE-1:0] slice_sum;
  assign rc[0] = carry_q;
  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_fa
      assign slice_sum[gi] = a_q[gi] ^ b_q[gi] ^ rc[gi];
      assign rc[gi+1]      = (a_q[gi] & b_q[gi]) | (rc[gi] & (a_q[gi] ^ b_q[gi]));
    end
  endgenerate

  // New slice result enters at the top; the wide concatenation keeps this
  // legal for CHUNKS=1, where the whole sum register is one slice.
  logic [W+SLICE-1:0] sum_cat;
  logic [W-1:0]       sum_shift;
  assign sum_cat   = {slice_sum, sum_q};
  assign sum_shift = sum_cat[W+SLICE-1:SLICE];

  // Operand B and carry preset as loaded at the accepting edge.
  logic [W-1:0] b_load;
  logic         carry_load;
`ifdef RCA_SEQ_SUB_EN
  assign b_load     = bus.op ? ~bus.b : bus.b;
  assign carry_load = bus.op;
`else
  assign b_load     = bus.b;
  assign carry_load = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_shift;
          a_q     <= a_q >> SLICE;
          b_q     <= b_q >> SLICE;
          carry_q <= rc[SLICE];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(CHUNKS - 1)) begin
            cout_q      <= rc[SLICE];
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_rca_slice_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rca_slice_sequencer
//   Self-checking bench for rca_slice_sequencer (SLICE=4, CHUNKS=8, W=32).
//   Expected results come from plain 33-bit arithmetic on the operands.
//   Optional feature macro: RCA_SEQ_SUB_EN (enables subtract cases).
// ---------------------------------------------------------------------------
module tb_rca_slice_sequencer;
  localparam int SLICE  = 4;
  localparam int CHUNKS = 8;
  localparam int W      = SLICE * CHUNKS;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  rca_slice_sequencer_if #(.W(W)) bus ();

  rca_slice_sequencer #(.SLICE(SLICE), .CHUNKS(CHUNKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {cout, sum} from unsigned arithmetic on the full operands.
  function automatic logic [W:0] ref_calc(input logic [W-1:0] av, input logic [W-1:0] bv,
                                          input bit opv);
    logic [W:0] r;
    if (opv) begin
      r[W-1:0] = av - bv;
      r[W]     = (av >= bv);
    end else begin
      r = {1'b0, av} + {1'b0, bv};
    end
    return r;
  endfunction

  task automatic drive_op(input bit opv);
`ifdef RCA_SEQ_SUB_EN
    bus.op = opv;
`endif
  endtask

  // One full transaction: accept, measure latency, check result, hold the
  // result for 'hold' cycles with res_ready low, then release it.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit opv, input int hold);
    int n;
    logic [W:0] exp;
    logic [W-1:0] s0;
    logic c0;
    exp = ref_calc(av, bv, opv);
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    drive_op(opv);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    drive_op(1'($urandom_range(0, 1)));
    check("busy_run", 64'(bus.busy), 64'd1);
    check("in_ready_run", 64'(bus.in_ready), 64'd0);
    n = 0;
    while (!bus.res_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(CHUNKS));
    check("sum", 64'(bus.sum), 64'(exp[W-1:0]));
    check("cout", 64'(bus.cout), 64'(exp[W]));
    s0 = bus.sum;
    c0 = bus.cout;
    for (int i = 0; i < hold; i++) begin
      bus.res_ready = 1'b0;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.a = $urandom;
      bus.b = $urandom;
      @(negedge clk);
      check("hold_sum", 64'(bus.sum), 64'(s0));
      check("hold_cout", 64'(bus.cout), 64'(c0));
      check("hold_valid", 64'(bus.res_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("release_valid", 64'(bus.res_valid), 64'd0);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    check("release_busy", 64'(bus.busy), 64'd0);
    $display("txn op=%0d a=0x%08h b=0x%08h -> sum=0x%08h cout=%0d lat=%0d hold=%0d",
             opv, av, bv, s0, c0, n, hold);
  endtask

  initial begin
    logic [W-1:0] qa [3];
    logic [W-1:0] qb [3];
    int t [3];
    int idx, got;
    bit acc_last;
    logic [W:0] e;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    drive_op(1'b0);
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_sum", 64'(bus.sum), 64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    rst_n = 1'b1;

    // Directed corner cases.
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);
    run_op(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5);   // backpressure

    // Reset during the 4th RUN cycle.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 32'hFFFF_FFFF;
    bus.b = 32'hFFFF_FFFF;
    drive_op(1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_valid", 64'(bus.res_valid), 64'd0);
    check("midrst_sum", 64'(bus.sum), 64'd0);
    check("midrst_cout", 64'(bus.cout), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h0000_0003, 32'h0000_0004, 1'b0, 0);

`ifdef RCA_SEQ_SUB_EN
    run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
    run_op(32'h0000_0007, 32'h0000_0005, 1'b1, 0);
    run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 0);
`endif

    // Randomized operands and backpressure.
    for (int i = 0; i < 16; i++) begin
      bit rop;
      rop = 1'b0;
`ifdef RCA_SEQ_SUB_EN
      rop = 1'($urandom_range(0, 1));
`endif
      run_op($urandom, $urandom, rop, $urandom_range(0, 3));
    end

    // Back-to-back: in_valid and res_ready held high.
    for (int i = 0; i < 3; i++) begin
      qa[i] = $urandom;
      qb[i] = $urandom;
      t[i]  = 0;
    end
    @(negedge clk);
    idx = 0;
    got = 0;
    acc_last = 1'b0;
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'b1;
    bus.a = qa[0];
    bus.b = qb[0];
    drive_op(1'b0);
    for (int cyc = 0; cyc < 100 && got < 3; cyc++) begin
      if (acc_last) begin
        idx++;
        if (idx < 3) begin
          bus.a = qa[idx];
          bus.b = qb[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      acc_last = bus.in_ready && bus.in_valid;
      if (bus.res_valid) begin
        e = ref_calc(qa[got], qb[got], 1'b0);
        check("b2b_sum", 64'(bus.sum), 64'(e[W-1:0]));
        check("b2b_cout", 64'(bus.cout), 64'(e[W]));
        $display("txn b2b #%0d a=0x%08h b=0x%08h -> sum=0x%08h cout=%0d cyc=%0d",
                 got, qa[got], qb[got], bus.sum, bus.cout, cyc);
        t[got] = cyc;
        got++;
      end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b0;
    check("b2b_count", 64'(got), 64'd3);
    check("b2b_gap01", 64'(t[1] - t[0]), 64'(CHUNKS + 2));
    check("b2b_gap12", 64'(t[2] - t[1]), 64'(CHUNKS + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
